// File: rtl/rule_cfg_responder.sv
// rule_cfg_responder: executes cfg2rule config reads/writes on the rule table and serves pipeline lookups
//   clk, rst                : clock, synchronous active-high reset
//   cfg2rule_cs/rw/addr/wdata : config request (held until ack), rw 1=write
//   rule2cfg_ack/rdata      : config completion (held until cs falls) and read data
//   lookup_req/index        : pipeline lookup, always wins the table
//   rule_valid/rule_data    : lookup result, one cycle after the request
module rule_cfg_responder #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8,
  parameter logic [15:0] STAT_ADDR = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg2rule_cs,
  input  logic             cfg2rule_rw,
  input  logic [15:0]      cfg2rule_addr,
  input  logic [31:0]      cfg2rule_wdata,
  output logic             rule2cfg_ack,
  output logic [31:0]      rule2cfg_rdata,
  input  logic             lookup_req,
  input  logic [IDX_W-1:0] lookup_index,
  output logic             rule_valid,
  output logic [31:0]      rule_data
);
  typedef enum logic [1:0] {IDLE, PEND, RDWAIT, ACK} state_t;
  state_t      r_state;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;
  logic [15:0] r_wr_cnt;
  logic        w_issue;
  logic        w_inr;
  // A config op only goes to the table in a PEND cycle the pipeline leaves free
  assign w_issue = r_state == PEND && cfg2rule_cs && !lookup_req;
  assign w_inr   = cfg2rule_addr < 16'(DEPTH);
  always_ff @(posedge clk) begin
    if (!rst && w_issue && cfg2rule_rw && w_inr) r_mem[cfg2rule_addr[IDX_W-1:0]] <= cfg2rule_wdata;
    if (w_issue && !cfg2rule_rw) r_q <= r_mem[cfg2rule_addr[IDX_W-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      rule2cfg_ack   <= 1'b0;
      rule2cfg_rdata <= 32'd0;
      rule_valid     <= 1'b0;
      rule_data      <= 32'd0;
      r_wr_cnt       <= 16'd0;
    end else begin
      rule_valid <= lookup_req;
      if (lookup_req) rule_data <= r_mem[lookup_index];
      case (r_state)
        IDLE: if (cfg2rule_cs) r_state <= PEND;
        PEND: begin
          if (!cfg2rule_cs) r_state <= IDLE;
          else if (!lookup_req) begin
            if (cfg2rule_rw) begin
              if (w_inr) r_wr_cnt <= r_wr_cnt + 16'd1;
              rule2cfg_ack <= 1'b1;
              r_state      <= ACK;
            end else if (w_inr) r_state <= RDWAIT;
            else begin
              rule2cfg_rdata <= cfg2rule_addr == STAT_ADDR ? {16'd0, r_wr_cnt} : 32'd0;
              rule2cfg_ack   <= 1'b1;
              r_state        <= ACK;
            end
          end
        end
        RDWAIT: begin
          rule2cfg_rdata <= r_q;
          rule2cfg_ack   <= 1'b1;
          r_state        <= ACK;
        end
        default: if (!cfg2rule_cs) begin
          rule2cfg_ack <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rule_cfg_responder.sv
// tb_rule_cfg_responder: table-driven config accesses with a lookup scoreboard
module tb_rule_cfg_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [31:0] wdata = 32'd0;
  logic        ack;
  logic [31:0] rdata;
  logic        lookup_req = 1'b0;
  logic [7:0]  lookup_index = 8'd0;
  logic        rule_valid;
  logic [31:0] rule_data;
  always #5 clk = ~clk;
  rule_cfg_responder dut (
    .clk(clk), .rst(rst),
    .cfg2rule_cs(cs), .cfg2rule_rw(rw), .cfg2rule_addr(addr), .cfg2rule_wdata(wdata),
    .rule2cfg_ack(ack), .rule2cfg_rdata(rdata),
    .lookup_req(lookup_req), .lookup_index(lookup_index),
    .rule_valid(rule_valid), .rule_data(rule_data)
  );
  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] wd;
    int          lk;
    int          hold;
    int          lat;
    logic [31:0] rd;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    int          due;
  } lk_t;
  int          pass_n = 0;
  int          tot_n = 0;
  int          cyc = 0;
  bit          en = 1'b0;
  lk_t         q[$];
  logic [31:0] m_mem [256];
  logic [31:0] last_rd = 32'd0;
  vec_t        v [12];
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tot_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, a, e);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (en) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("lk_valid", 32'(rule_valid), 32'd1);
      chk("lk_data", rule_data, q[0].d);
      void'(q.pop_front());
    end else if (rule_valid) chk("lk_spurious", 32'(rule_valid), 32'd0);
  end
  task automatic push_lk(input logic [7:0] idx);
    lookup_req   = 1'b1;
    lookup_index = idx;
    q.push_back('{m_mem[idx], cyc + 1});
  endtask
  task automatic cfg(input vec_t t);
    int n;
    logic [31:0] erd;
    erd = t.rw ? last_rd : t.rd;
    cs = 1'b1; rw = t.rw; addr = t.addr; wdata = t.wd;
    n = 0;
    while (n < 40) begin
      tick;
      n++;
      if (ack) break;
      lookup_req = 1'b0;
      if (n <= t.lk) push_lk(t.addr[7:0]);
      if (n >= t.lk + 2) begin
        rw = ~t.rw; addr = ~t.addr; wdata = ~t.wd;
      end
    end
    lookup_req = 1'b0;
    chk("ack_lat", 32'(n), 32'(t.lat));
    chk("rdata", rdata, erd);
    for (int i = 0; i < t.hold; i++) begin
      tick;
      chk("ack_hold", 32'(ack), 32'd1);
      chk("rdata_hold", rdata, erd);
    end
    cs = 1'b0;
    tick;
    chk("ack_fall", 32'(ack), 32'd0);
    chk("rdata_keep", rdata, erd);
    if (!t.rw) last_rd = t.rd;
    else if (t.addr < 16'd256) m_mem[t.addr[7:0]] = t.wd;
  endtask
  initial begin
    v[0]  = '{1'b1, 16'h0010, 32'hA5A5_0001, 0, 0,  2, 32'h0};
    v[1]  = '{1'b0, 16'h0010, 32'h0,         0, 0,  3, 32'hA5A5_0001};
    v[2]  = '{1'b1, 16'h0020, 32'h1111_2222, 0, 0,  2, 32'h0};
    v[3]  = '{1'b1, 16'h0020, 32'h3333_4444, 5, 0,  7, 32'h0};
    v[4]  = '{1'b0, 16'h0020, 32'h0,         0, 10, 3, 32'h3333_4444};
    v[5]  = '{1'b1, 16'h0000, 32'hCAFE_0000, 0, 0,  2, 32'h0};
    v[6]  = '{1'b1, 16'h0100, 32'hDEAD_BEEF, 0, 0,  2, 32'h0};
    v[7]  = '{1'b0, 16'h0100, 32'h0,         0, 0,  2, 32'h0};
    v[8]  = '{1'b0, 16'hFFFF, 32'h0,         0, 0,  2, 32'h0000_0004};
    v[9]  = '{1'b1, 16'hFFFF, 32'h1234_5678, 0, 0,  2, 32'h0};
    v[10] = '{1'b0, 16'hFFFF, 32'h0,         0, 0,  2, 32'h0000_0004};
    v[11] = '{1'b0, 16'h0000, 32'h0,         2, 3,  5, 32'hCAFE_0000};
    repeat (3) tick;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_valid", 32'(rule_valid), 32'd0);
    chk("rst_rule_data", rule_data, 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    tick;
    for (int i = 0; i < 12; i++) cfg(v[i]);
    // cs withdrawn while stalled in PEND: no op, no ack
    cs = 1'b1; rw = 1'b1; addr = 16'h0010; wdata = 32'h0;
    tick;
    push_lk(8'h10);
    tick;
    lookup_req = 1'b0;
    cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_no_ack", 32'(ack), 32'd0);
    end
    cfg('{1'b0, 16'h0010, 32'h0, 0, 0, 3, 32'hA5A5_0001});
    cfg('{1'b0, 16'hFFFF, 32'h0, 0, 0, 2, 32'h0000_0004});
    // preload the counter directly rather than issuing 64k writes
    dut.r_wr_cnt = 16'hFFFE;
    cfg('{1'b1, 16'h0050, 32'h5050_5050, 0, 0, 2, 32'h0});
    cfg('{1'b0, 16'hFFFF, 32'h0, 0, 0, 2, 32'h0000_FFFF});
    cfg('{1'b1, 16'h0051, 32'h5151_5151, 0, 0, 2, 32'h0});
    cfg('{1'b0, 16'hFFFF, 32'h0, 0, 0, 2, 32'h0000_0000});
    // reset while a write waits in PEND
    cfg('{1'b1, 16'h0040, 32'h0101_0101, 0, 0, 2, 32'h0});
    cs = 1'b1; rw = 1'b1; addr = 16'h0040; wdata = 32'hBADB_AD00;
    tick;
    rst = 1'b1;
    tick;
    chk("rstp_ack", 32'(ack), 32'd0);
    chk("rstp_rdata", rdata, 32'd0);
    rst = 1'b0; cs = 1'b0; last_rd = 32'd0;
    tick;
    cfg('{1'b0, 16'hFFFF, 32'h0, 0, 0, 2, 32'h0000_0000});
    cfg('{1'b0, 16'h0040, 32'h0, 0, 0, 3, 32'h0101_0101});
    // reset while a read waits in RDWAIT
    cs = 1'b1; rw = 1'b0; addr = 16'h0040;
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("rstr_ack", 32'(ack), 32'd0);
    chk("rstr_rdata", rdata, 32'd0);
    rst = 1'b0; cs = 1'b0; last_rd = 32'd0;
    tick;
    cfg('{1'b0, 16'h0040, 32'h0, 0, 0, 3, 32'h0101_0101});
    repeat (3) tick;
    chk("lk_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
